// File: rtl/nibble_serial_adder_if.sv
// Request/response bundle for the digit-serial adder/subtractor.
// The master presents operands and consumes results; the slave is the adder.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
) ();
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         overflow;

    modport master (
        output in_valid, a, b, cin, op_sub, out_ready,
        input  in_ready, out_valid, result, carry, zero, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, op_sub, out_ready,
        output in_ready, out_valid, result, carry, zero, overflow
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Digit-serial add/subtract: one 4-bit digit per cycle, LSB digit first,
// with a valid/ready request side and a valid/ready result side.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high once out of reset
// RUN   | processing one digit per edge, carry held in r_c
// DONE  | result and flags held until out_ready
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_adder_if.slave  bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_c;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_sub;
    logic [W-1:0]  r_sum;
    logic          r_carry;
    logic          r_zero;
    logic          r_ovf;
    logic          r_in_ready;
    logic          r_out_valid;

    logic [CW+1:0] w_base;
    logic [4:0]    w_dsum;
    logic          w_last;
    logic [W-1:0]  w_final;

    assign w_base = {r_cnt, 2'b00};
    assign w_last = (r_cnt == CW'(NIBBLES - 1));
    assign w_dsum = {1'b0, r_a[w_base +: 4]} + {1'b0, r_b[w_base +: 4]} + {4'b0000, r_c};

    // Full result as it will look once the top digit lands; flags come from this.
    always_comb begin
        w_final = r_sum;
        w_final[W-1 -: 4] = w_dsum[3:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_c         <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b1;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready) begin
                        // b is stored pre-inverted for subtract; carry-in doubles as borrow.
                        r_a        <= bus.a;
                        r_b        <= bus.op_sub ? ~bus.b : bus.b;
                        r_sub      <= bus.op_sub;
                        r_c        <= bus.cin ^ bus.op_sub;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum[w_base +: 4] <= w_dsum[3:0];
                    r_c                <= w_dsum[4];
                    r_cnt              <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_carry     <= w_dsum[4] ^ r_sub;
                        r_zero      <= (w_final == '0);
                        r_ovf       <= (r_a[W-1] == r_b[W-1]) && (w_dsum[3] != r_a[W-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_sum;
    assign bus.carry     = r_carry;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed corner cases plus random traffic
// against an arithmetic reference model.
module tb_nibble_serial_adder;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   last_acc_cyc;

    nibble_serial_adder_if #(.NIBBLES(NIB)) bus ();

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
        $fatal(1);
    end

    // Reference: plain integer arithmetic, signed range check for overflow.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub,
                                  output logic [W-1:0] r, output logic c,
                                  output logic z, output logic o);
        longint ua, ub, sa, sb, u, s, lim;
        lim = longint'(1) << (W - 1);
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = (ua >= lim) ? ua - 2 * lim : ua;
        sb  = (ub >= lim) ? ub - 2 * lim : ub;
        if (!sub) begin
            u = ua + ub + longint'(cin);
            s = sa + sb + longint'(cin);
            c = (u >= 2 * lim);
        end else begin
            u = ua - ub - longint'(cin);
            s = sa - sb - longint'(cin);
            c = (u < 0);
        end
        r = W'(u);
        z = (r == '0);
        o = (s >= lim) || (s < -lim);
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input bit scramble,
                         output logic [W-1:0] r, output logic c, output logic z,
                         output logic o, output int lat, output bit to);
        bit acc;
        int n;
        to = 0;
        lat = 0;
        r = '0; c = 1'b0; z = 1'b0; o = 1'b0;
        bus.a = a; bus.b = b; bus.cin = cin; bus.op_sub = sub;
        bus.in_valid = 1'b1;
        acc = 0;
        n = 0;
        while (!acc && n < 20) begin
            acc = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            to = 1;
            return;
        end
        last_acc_cyc = cyc;
        while (!bus.out_valid && lat < 20) begin
            if (scramble) begin
                bus.a = W'($urandom); bus.b = W'($urandom);
                bus.cin = 1'($urandom); bus.op_sub = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) to = 1;
        r = bus.result; c = bus.carry; z = bus.zero; o = bus.overflow;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.op_sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.carry !== 1'b0 ||
            bus.zero !== 1'b1 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got ov=%b res=%h c=%b z=%b o=%b, want 0 0000 0 1 0",
                     bus.out_valid, bus.result, bus.carry, bus.zero, bus.overflow);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [6];
        logic [W-1:0] tb [6];
        logic         tc [6];
        logic         ts [6];
        logic [W-1:0] r, er;
        logic c, z, o, ec, ez, eo;
        int lat;
        bit to;
        ta = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0003, 16'h8000, 16'h0000};
        tb = '{16'h0001, 16'h0001, 16'h0000, 16'h0005, 16'h0001, 16'h0000};
        tc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        ts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            model(ta[i], tb[i], tc[i], ts[i], er, ec, ez, eo);
            do_op(ta[i], tb[i], tc[i], ts[i], 1'b0, r, c, z, o, lat, to);
            checks++;
            if (to || r !== er || c !== ec || z !== ez || o !== eo) begin
                errors++;
                $display("FAIL directed_%0d: got res=%h c=%b z=%b o=%b to=%b, want res=%h c=%b z=%b o=%b",
                         i, r, c, z, o, to, er, ec, ez, eo);
            end
            checks++;
            if (lat != NIB) begin
                errors++;
                $display("FAIL directed_latency_%0d: got %0d edges want %0d", i, lat, NIB);
            end
        end
        checks++;
        if (r !== 16'hFFFF || c !== 1'b1) begin
            errors++;
            $display("FAIL sub_zero_minus_borrow: got res=%h c=%b want ffff 1", r, c);
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] a0, b0, a1, b1, er, snap;
        logic c0, s0, c1, s1, ec, ez, eo;
        logic [3:0] fsnap;
        bit acc;
        int n;
        a0 = W'($urandom); b0 = W'($urandom); c0 = 1'($urandom); s0 = 1'($urandom);
        model(a0, b0, c0, s0, er, ec, ez, eo);
        bus.a = a0; bus.b = b0; bus.cin = c0; bus.op_sub = s0; bus.in_valid = 1'b1;
        acc = 0; n = 0;
        while (!acc && n < 20) begin
            acc = bus.in_ready; @(posedge clk); #1; n++;
        end
        n = 0;
        while (!bus.out_valid && n < 20) begin
            bus.a = W'($urandom); @(posedge clk); #1; n++;
        end
        checks++;
        if (!acc || bus.out_valid !== 1'b1 || bus.result !== er ||
            {bus.carry, bus.zero, bus.overflow} !== {ec, ez, eo}) begin
            errors++;
            $display("FAIL hold_result: got ov=%b res=%h flags=%b%b%b want res=%h flags=%b%b%b",
                     bus.out_valid, bus.result, bus.carry, bus.zero, bus.overflow, er, ec, ez, eo);
        end
        snap = bus.result;
        fsnap = {bus.carry, bus.zero, bus.overflow, bus.out_valid};
        for (int i = 0; i < 5; i++) begin
            bus.a = W'($urandom); bus.b = W'($urandom);
            bus.cin = 1'($urandom); bus.op_sub = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if (bus.result !== snap || {bus.carry, bus.zero, bus.overflow, bus.out_valid} !== fsnap ||
                bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable_%0d: got res=%h flags=%b rdy=%b want res=%h flags=%b rdy=0",
                         i, bus.result, {bus.carry, bus.zero, bus.overflow, bus.out_valid},
                         bus.in_ready, snap, fsnap);
            end
        end
        a1 = bus.a; b1 = bus.b; c1 = bus.cin; s1 = bus.op_sub;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got ov=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_next_accept: in_ready got %b want 0", bus.in_ready);
        end
        model(a1, b1, c1, s1, er, ec, ez, eo);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n != NIB || bus.result !== er || {bus.carry, bus.zero, bus.overflow} !== {ec, ez, eo}) begin
            errors++;
            $display("FAIL hold_second_op: got lat=%0d res=%h flags=%b%b%b want lat=%0d res=%h flags=%b%b%b",
                     n, bus.result, bus.carry, bus.zero, bus.overflow, NIB, er, ec, ez, eo);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] r, er;
        logic c, z, o, ec, ez, eo;
        int lat, seen;
        bit acc, to;
        int n;
        bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.op_sub = 1'b0;
        bus.in_valid = 1'b1;
        acc = 0; n = 0;
        while (!acc && n < 20) begin
            acc = bus.in_ready; @(posedge clk); #1; n++;
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (!acc || bus.out_valid !== 1'b0 || bus.result !== '0 || bus.carry !== 1'b0 ||
            bus.zero !== 1'b1 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset_values: got acc=%b ov=%b res=%h c=%b z=%b o=%b want 1 0 0000 0 1 0",
                     acc, bus.out_valid, bus.result, bus.carry, bus.zero, bus.overflow);
        end
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midrun_no_out_valid: got %0d valid cycles want 0", seen);
        end
        model(16'h1234, 16'h4321, 1'b0, 1'b0, er, ec, ez, eo);
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, r, c, z, o, lat, to);
        checks++;
        if (to || r !== 16'h5555 || r !== er || {c, z, o} !== {ec, ez, eo}) begin
            errors++;
            $display("FAIL post_reset_add: got res=%h flags=%b%b%b to=%b want 5555 flags=%b%b%b",
                     r, c, z, o, to, ec, ez, eo);
        end
        // Reset on the same edge as a pending request must win.
        bus.in_valid = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_vs_request: got valid_cycles=%0d rdy=%b want 0 1", seen, bus.in_ready);
        end
    endtask

    task automatic test_input_change();
        logic [W-1:0] a, b, r, er;
        logic ci, s, c, z, o, ec, ez, eo;
        int lat;
        bit to;
        for (int i = 0; i < 4; i++) begin
            a = W'($urandom); b = W'($urandom); ci = 1'($urandom); s = 1'(i);
            model(a, b, ci, s, er, ec, ez, eo);
            do_op(a, b, ci, s, 1'b1, r, c, z, o, lat, to);
            checks++;
            if (to || r !== er || {c, z, o} !== {ec, ez, eo}) begin
                errors++;
                $display("FAIL input_change_%0d: got res=%h flags=%b%b%b want res=%h flags=%b%b%b",
                         i, r, c, z, o, er, ec, ez, eo);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b, r, er;
        logic ci, s, c, z, o, ec, ez, eo;
        int lat, prev, bad_sp;
        bit to;
        prev = -1;
        bad_sp = 0;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom); b = W'($urandom);
            if (i % 5 == 0) b = ~a;
            if (i % 7 == 0) b = a;
            ci = 1'($urandom); s = 1'($urandom);
            model(a, b, ci, s, er, ec, ez, eo);
            do_op(a, b, ci, s, 1'b0, r, c, z, o, lat, to);
            checks++;
            if (to || lat != NIB || r !== er || {c, z, o} !== {ec, ez, eo}) begin
                errors++;
                $display("FAIL random_%0d: a=%h b=%h cin=%b sub=%b got res=%h flags=%b%b%b lat=%0d want res=%h flags=%b%b%b lat=%0d",
                         i, a, b, ci, s, r, c, z, o, lat, er, ec, ez, eo, NIB);
            end
            if (prev >= 0 && last_acc_cyc - prev != NIB + 2) bad_sp++;
            prev = last_acc_cyc;
        end
        checks++;
        if (bad_sp != 0) begin
            errors++;
            $display("FAIL back_to_back_spacing: got %0d bad gaps want 0 (gap %0d)", bad_sp, NIB + 2);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_acc_cyc = 0;
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_input_change();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
